dram_read_master: RTL and testbench

AXI4 read master that services the pixel pipeline's DRAM read-request interface (`dram_read_addr`/`dram_read_len`/`dram_read_en`) and returns beats on `dram_read_data`/`dram_read_data_valid`. It is the responding end of the interface the image sender drives: one request becomes one or two INCR bursts on the PS DDR port, split at 4 KB boundaries. Consumer backpressure through `dram_buffer_full` throttles `m_axi_rready`.

---
 rtl/image_ctrl_pkg.sv | 21 ++
 rtl/dram_read_master_if.sv | 55 +++++
 rtl/dram_read_master.sv | 120 ++++++++++++
 tb/tb_dram_read_master.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_ctrl_pkg.sv
// Shared definitions for the image controller DRAM path: read-master FSM states,
// AXI encodings and the 4 KB burst-split helper.
package image_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StAddr, StData} rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR      = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY       = 2'b00;
  localparam logic [3:0] AXI_ARCACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AXI_ARSIZE_16B      = 3'd4;
  localparam int unsigned BOUNDARY_BEATS     = 256;

  // Works in "minus one" form so arlen = min(remaining, to_boundary) - 1 fits in 8 bits.
  function automatic logic [7:0] calc_arlen(input logic [7:0] beat_off,
                                            input logic [7:0] rem_m1);
    logic [7:0] to_bnd_m1;
    to_bnd_m1 = 8'(BOUNDARY_BEATS - 1) - beat_off;
    return (rem_m1 < to_bnd_m1) ? rem_m1 : to_bnd_m1;
  endfunction

endpackage

// File: rtl/dram_read_master_if.sv
// Bundles the pixel-pipeline read-request port and the AXI4 read channels of
// dram_read_master; master is the DUT view, slave the requester/interconnect view.
interface dram_read_master_if #(
  parameter int unsigned DRAM_ADDR_WIDTH = 39,
  parameter int unsigned DRAM_DATA_WIDTH = 128,
  parameter int unsigned AXI_ID_WIDTH    = 16
);

  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr;
  logic [7:0]                 dram_read_len;
  logic                       dram_read_en;
  logic                       dram_buffer_full;
  logic [DRAM_DATA_WIDTH-1:0] dram_read_data;
  logic                       dram_read_data_valid;
  logic                       dram_read_busy;
  logic                       dram_read_error;

  logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]                 m_axi_arlen;
  logic [2:0]                 m_axi_arsize;
  logic [1:0]                 m_axi_arburst;
  logic [3:0]                 m_axi_arcache;
  logic [2:0]                 m_axi_arprot;
  logic [AXI_ID_WIDTH-1:0]    m_axi_arid;
  logic                       m_axi_arvalid;
  logic                       m_axi_arready;

  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]                 m_axi_rresp;
  logic                       m_axi_rlast;
  logic [AXI_ID_WIDTH-1:0]    m_axi_rid;
  logic                       m_axi_rvalid;
  logic                       m_axi_rready;

  modport master (
    input  dram_read_addr, dram_read_len, dram_read_en, dram_buffer_full,
    output dram_read_data, dram_read_data_valid, dram_read_busy, dram_read_error,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache,
    output m_axi_arprot, m_axi_arid, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output dram_read_addr, dram_read_len, dram_read_en, dram_buffer_full,
    input  dram_read_data, dram_read_data_valid, dram_read_busy, dram_read_error,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache,
    input  m_axi_arprot, m_axi_arid, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/dram_read_master.sv
// AXI4 read master: turns one pixel-pipeline read request into one or two INCR
// bursts split at 4 KB, returning beats with consumer backpressure on RREADY.
module dram_read_master
  import image_ctrl_pkg::*;
#(
  parameter int unsigned DRAM_ADDR_WIDTH = 39,
  parameter int unsigned DRAM_DATA_WIDTH = 128,
  parameter int unsigned AXI_ID_WIDTH    = 16
) (
  input logic                m_axi_aclk,
  input logic                m_axi_aresetn,
  dram_read_master_if.master bus
);

  rd_state_e                  r_state;
  logic [DRAM_ADDR_WIDTH-1:0] r_addr;
  logic [DRAM_ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]                 r_rem_m1;
  logic [7:0]                 r_arlen;
  logic [7:0]                 r_beat_cnt;
  logic                       r_arvalid;
  logic                       r_busy;
  logic                       r_error;
  logic                       r_rvalid;
  logic [DRAM_DATA_WIDTH-1:0] r_rdata;

  logic       w_rready;
  logic       w_r_hs;
  logic       w_beat_last;
  logic       w_req_done;
  logic [7:0] w_arlen;
  logic [12:0] w_burst_bytes;
  logic       w_unused;

  assign w_rready      = (r_state == StData) & ~bus.dram_buffer_full;
  assign w_r_hs        = bus.m_axi_rvalid & w_rready;
  assign w_beat_last   = (r_beat_cnt == r_arlen);
  assign w_req_done    = (r_rem_m1 == r_arlen);
  assign w_arlen       = calc_arlen(r_addr[11:4], r_rem_m1);
  assign w_burst_bytes = {({1'b0, r_arlen} + 9'd1), 4'b0000};
  assign w_unused      = ^{bus.m_axi_rid, bus.dram_read_addr[3:0]};

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_araddr   <= '0;
      r_rem_m1   <= '0;
      r_arlen    <= '0;
      r_beat_cnt <= '0;
      r_arvalid  <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.dram_read_en) begin
            r_addr   <= {bus.dram_read_addr[DRAM_ADDR_WIDTH-1:4], 4'b0000};
            r_rem_m1 <= bus.dram_read_len;
            r_busy   <= 1'b1;
            r_state  <= StAddr;
          end
        end
        StAddr: begin
          // First cycle in ADDR loads the burst; AR then holds until accepted.
          if (!r_arvalid) begin
            r_arvalid <= 1'b1;
            r_araddr  <= r_addr;
            r_arlen   <= w_arlen;
          end else if (bus.m_axi_arready) begin
            r_arvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= StData;
          end
        end
        StData: begin
          if (w_r_hs) begin
            r_rdata  <= bus.m_axi_rdata;
            r_rvalid <= 1'b1;
            if ((bus.m_axi_rresp != AXI_RESP_OKAY) || (bus.m_axi_rlast != w_beat_last)) begin
              r_error <= 1'b1;
            end
            // Burst ends on the counted beat, whatever RLAST says.
            if (w_beat_last) begin
              r_addr   <= r_addr + DRAM_ADDR_WIDTH'(w_burst_bytes);
              r_rem_m1 <= r_rem_m1 - r_arlen - 8'd1;
              if (w_req_done) begin
                r_busy  <= 1'b0;
                r_state <= StIdle;
              end else begin
                r_state <= StAddr;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.m_axi_araddr         = r_araddr;
  assign bus.m_axi_arlen          = r_arlen;
  assign bus.m_axi_arsize         = AXI_ARSIZE_16B;
  assign bus.m_axi_arburst        = AXI_BURST_INCR;
  assign bus.m_axi_arcache        = AXI_ARCACHE_DEFAULT;
  assign bus.m_axi_arprot         = '0;
  assign bus.m_axi_arid           = '0;
  assign bus.m_axi_arvalid        = r_arvalid;
  assign bus.m_axi_rready         = w_rready;
  assign bus.dram_read_data       = r_rdata;
  assign bus.dram_read_data_valid = r_rvalid;
  assign bus.dram_read_busy       = r_busy;
  assign bus.dram_read_error      = r_error;

endmodule

// File: tb/tb_dram_read_master.sv
// Directed bench for dram_read_master: behavioural AXI read slave plus per-scenario
// tasks with hand-computed bursts, beat data and flag values.
module tb_dram_read_master;

  localparam int unsigned AW = 39;
  localparam int unsigned DW = 128;
  localparam int unsigned IW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_read_master_if #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) bus ();

  dram_read_master #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rst_n),
    .bus          (bus)
  );

  int total = 0;
  int bad   = 0;

  // Slave knobs
  int ar_stall_cfg = 0;
  int err_beat_cfg = -1;
  bit full_toggle  = 1'b0;
  bit rlast_drop   = 1'b0;

  // Slave / monitor state
  logic [AW-1:0] ar_addr_log[$];
  logic [7:0]    ar_len_log[$];
  logic [AW-1:0] pend_addr[$];
  logic [7:0]    pend_len[$];
  logic [DW-1:0] cap[$];
  bit            r_active;
  logic [AW-1:0] r_base;
  logic [7:0]    r_len;
  int            r_beat;
  int            req_hs;
  bit            s_ar_hs, s_r_hs;
  logic [AW-1:0] s_ar_addr, ar_prev_addr;
  logic [7:0]    s_ar_len, ar_prev_len;
  bit            ar_prev_stall;
  int            ar_cnt, ar_unstable, ar_stall_seen;
  int            rr_bad, rr_checks;
  bit            prev_busy, fall_dv;
  int            fall_hs;

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
    return {64'hC0DE_C0DE_C0DE_C0DE, 25'd0, a};
  endfunction

  // AXI read slave: drives at negedge, samples handshakes 1 ns before posedge.
  initial begin
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0;
    bus.m_axi_rresp = 2'b00; bus.m_axi_rlast = 1'b0; bus.m_axi_rid = '0;
    bus.dram_buffer_full = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_addr.delete(); pend_len.delete();
        r_active = 1'b0; s_ar_hs = 1'b0; s_r_hs = 1'b0; ar_cnt = 0; ar_prev_stall = 1'b0;
        bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
        bus.m_axi_rresp = 2'b00; bus.m_axi_rdata = '0; bus.dram_buffer_full = 1'b0;
      end else begin
        if (s_ar_hs) begin
          ar_addr_log.push_back(s_ar_addr); ar_len_log.push_back(s_ar_len);
          pend_addr.push_back(s_ar_addr); pend_len.push_back(s_ar_len);
        end
        if (s_r_hs) begin
          req_hs++;
          if (r_beat == int'(r_len)) r_active = 1'b0;
          else r_beat++;
        end
        if (!r_active && pend_addr.size() > 0) begin
          r_base = pend_addr.pop_front(); r_len = pend_len.pop_front();
          r_beat = 0; r_active = 1'b1;
        end
        if (bus.m_axi_arvalid) begin
          bus.m_axi_arready = (ar_cnt >= ar_stall_cfg); ar_cnt++;
        end else begin
          bus.m_axi_arready = 1'b0; ar_cnt = 0;
        end
        bus.m_axi_rvalid = r_active;
        bus.m_axi_rdata  = r_active ? beat_data(r_base + AW'(16 * r_beat)) : '0;
        bus.m_axi_rlast  = r_active && (r_beat == int'(r_len)) && !rlast_drop;
        bus.m_axi_rresp  = (r_active && req_hs == err_beat_cfg) ? 2'b10 : 2'b00;
        bus.dram_buffer_full = full_toggle ? ~bus.dram_buffer_full : 1'b0;
      end
      #4;
      s_ar_hs   = bus.m_axi_arvalid & bus.m_axi_arready;
      s_ar_addr = bus.m_axi_araddr;
      s_ar_len  = bus.m_axi_arlen;
      s_r_hs    = bus.m_axi_rvalid & bus.m_axi_rready;
      if (bus.m_axi_arvalid && ar_prev_stall &&
          (bus.m_axi_araddr !== ar_prev_addr || bus.m_axi_arlen !== ar_prev_len)) ar_unstable++;
      if (bus.m_axi_arvalid && !bus.m_axi_arready) ar_stall_seen++;
      ar_prev_stall = bus.m_axi_arvalid & ~bus.m_axi_arready;
      ar_prev_addr  = bus.m_axi_araddr;
      ar_prev_len   = bus.m_axi_arlen;
      if (r_active) begin
        rr_checks++;
        if (bus.m_axi_rready !== ~bus.dram_buffer_full) rr_bad++;
      end
      if (bus.dram_read_data_valid === 1'b1) cap.push_back(bus.dram_read_data);
      if (prev_busy && bus.dram_read_busy === 1'b0) begin
        fall_dv = bus.dram_read_data_valid; fall_hs = req_hs;
      end
      prev_busy = (bus.dram_read_busy === 1'b1);
    end
  end

  task automatic clear_logs();
    ar_addr_log.delete(); ar_len_log.delete(); cap.delete();
    req_hs = 0; fall_dv = 1'b0; fall_hs = -1;
    ar_unstable = 0; ar_stall_seen = 0; rr_bad = 0; rr_checks = 0;
  endtask

  task automatic issue(input logic [AW-1:0] addr, input logic [7:0] len);
    @(negedge clk);
    bus.dram_read_addr = addr; bus.dram_read_len = len; bus.dram_read_en = 1'b1;
    @(negedge clk);
    bus.dram_read_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int n = 0;
    while (bus.dram_read_busy === 1'b1 && n < budget) begin
      @(negedge clk); n++;
    end
    timed_out = (bus.dram_read_busy !== 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 8;
    if (bus.m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b want=0", bus.m_axi_arvalid); end
    if (bus.m_axi_rready !== 1'b0) begin bad++; $display("FAIL rst_rready got=%b want=0", bus.m_axi_rready); end
    if (bus.dram_read_data_valid !== 1'b0) begin bad++; $display("FAIL rst_dv got=%b want=0", bus.dram_read_data_valid); end
    if (bus.dram_read_data !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.dram_read_data); end
    if (bus.dram_read_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.dram_read_busy); end
    if (bus.dram_read_error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b want=0", bus.dram_read_error); end
    if (bus.m_axi_araddr !== '0) begin bad++; $display("FAIL rst_araddr got=%h want=0", bus.m_axi_araddr); end
    if (bus.m_axi_arlen !== 8'd0) begin bad++; $display("FAIL rst_arlen got=%0d want=0", bus.m_axi_arlen); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    logic [DW-1:0] got;
    clear_logs();
    issue(39'h0_1000_0000, 8'd15);
    total += 2;
    if (bus.dram_read_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%b want=1", bus.dram_read_busy); end
    if (bus.m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL basic_arvalid_early got=%b want=0", bus.m_axi_arvalid); end
    @(negedge clk);
    total += 2;
    if (bus.m_axi_arvalid !== 1'b1) begin bad++; $display("FAIL basic_arvalid_rise got=%b want=1", bus.m_axi_arvalid); end
    if (bus.m_axi_rready !== 1'b0) begin bad++; $display("FAIL basic_rready_in_addr got=%b want=0", bus.m_axi_rready); end
    wait_idle(200, to);
    total += 10;
    if (to) begin bad++; $display("FAIL basic_timeout busy=%b want 0", bus.dram_read_busy); end
    if (ar_addr_log.size() != 1) begin bad++; $display("FAIL basic_ar_count got=%0d want=1", ar_addr_log.size()); end
    if (ar_addr_log[0] !== 39'h0_1000_0000) begin bad++; $display("FAIL basic_araddr got=%h want=10000000", ar_addr_log[0]); end
    if (ar_len_log[0] !== 8'd15) begin bad++; $display("FAIL basic_arlen got=%0d want=15", ar_len_log[0]); end
    if (bus.m_axi_arsize !== 3'd4) begin bad++; $display("FAIL basic_arsize got=%0d want=4", bus.m_axi_arsize); end
    if (bus.m_axi_arburst !== 2'd1) begin bad++; $display("FAIL basic_arburst got=%0d want=1", bus.m_axi_arburst); end
    if (bus.m_axi_arcache !== 4'b0011 || bus.m_axi_arprot !== 3'd0 || bus.m_axi_arid !== '0) begin
      bad++; $display("FAIL basic_ar_attr got=cache %h prot %h id %h want=3/0/0",
                      bus.m_axi_arcache, bus.m_axi_arprot, bus.m_axi_arid);
    end
    if (cap.size() != 16) begin bad++; $display("FAIL basic_strobes got=%0d want=16", cap.size()); end
    if (fall_dv !== 1'b1 || fall_hs != 16) begin
      bad++; $display("FAIL basic_busy_fall got=dv %b hs %0d want=dv 1 hs 16", fall_dv, fall_hs);
    end
    if (bus.dram_read_error !== 1'b0) begin bad++; $display("FAIL basic_error got=%b want=0", bus.dram_read_error); end
    for (int i = 0; i < 16; i++) begin
      got = (i < cap.size()) ? cap[i] : '0;
      total++;
      if (got !== beat_data(39'h0_1000_0000 + AW'(16 * i))) begin
        bad++; $display("FAIL basic_beat%0d got=%h want=%h", i, got, beat_data(39'h0_1000_0000 + AW'(16 * i)));
      end
    end
  endtask

  task automatic test_boundary();
    bit to;
    logic [DW-1:0] got;
    clear_logs();
    issue(39'h0FC0, 8'd7);
    wait_idle(200, to);
    total += 3;
    if (to) begin bad++; $display("FAIL bnd_timeout busy=%b want 0", bus.dram_read_busy); end
    if (ar_addr_log.size() != 2) begin
      bad++; $display("FAIL bnd_ar_count got=%0d want=2", ar_addr_log.size());
    end else begin
      total += 4;
      if (ar_addr_log[0] !== 39'h0FC0) begin bad++; $display("FAIL bnd_araddr0 got=%h want=fc0", ar_addr_log[0]); end
      if (ar_len_log[0] !== 8'd3) begin bad++; $display("FAIL bnd_arlen0 got=%0d want=3", ar_len_log[0]); end
      if (ar_addr_log[1] !== 39'h1000) begin bad++; $display("FAIL bnd_araddr1 got=%h want=1000", ar_addr_log[1]); end
      if (ar_len_log[1] !== 8'd3) begin bad++; $display("FAIL bnd_arlen1 got=%0d want=3", ar_len_log[1]); end
    end
    if (cap.size() != 8) begin bad++; $display("FAIL bnd_strobes got=%0d want=8", cap.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i < cap.size()) ? cap[i] : '0;
      total++;
      if (got !== beat_data(39'h0FC0 + AW'(16 * i))) begin
        bad++; $display("FAIL bnd_beat%0d got=%h want=%h", i, got, beat_data(39'h0FC0 + AW'(16 * i)));
      end
    end
  endtask

  task automatic test_max_burst();
    bit to;
    int errs = 0;
    clear_logs();
    issue(39'h0, 8'd255);
    wait_idle(800, to);
    total += 5;
    if (to) begin bad++; $display("FAIL max_timeout busy=%b want 0", bus.dram_read_busy); end
    if (ar_addr_log.size() != 1) begin bad++; $display("FAIL max_ar_count got=%0d want=1", ar_addr_log.size()); end
    if (ar_len_log.size() < 1 || ar_len_log[0] !== 8'd255) begin
      bad++; $display("FAIL max_arlen got=%0d want=255", (ar_len_log.size() > 0) ? ar_len_log[0] : 8'd0);
    end
    if (cap.size() != 256) begin bad++; $display("FAIL max_strobes got=%0d want=256", cap.size()); end
    for (int i = 0; i < 256 && i < cap.size(); i++) begin
      if (cap[i] !== beat_data(AW'(16 * i))) errs++;
    end
    if (errs != 0) begin bad++; $display("FAIL max_data got=%0d wrong beats want=0", errs); end
  endtask

  task automatic test_ar_backpressure();
    bit to;
    clear_logs();
    ar_stall_cfg = 5;
    issue(39'h3000, 8'd3);
    wait_idle(200, to);
    ar_stall_cfg = 0;
    total += 6;
    if (to) begin bad++; $display("FAIL arbp_timeout busy=%b want 0", bus.dram_read_busy); end
    if (ar_stall_seen != 5) begin bad++; $display("FAIL arbp_stall_cycles got=%0d want=5", ar_stall_seen); end
    if (ar_unstable != 0) begin bad++; $display("FAIL arbp_stable got=%0d changes want=0", ar_unstable); end
    if (ar_addr_log.size() != 1) begin bad++; $display("FAIL arbp_hs_count got=%0d want=1", ar_addr_log.size()); end
    if (ar_addr_log.size() < 1 || ar_addr_log[0] !== 39'h3000 || ar_len_log[0] !== 8'd3) begin
      bad++; $display("FAIL arbp_ar got=size %0d want=3000/3", ar_addr_log.size());
    end
    if (cap.size() != 4 || cap[3] !== beat_data(39'h3030)) begin
      bad++; $display("FAIL arbp_data got=%0d strobes want=4 ending %h", cap.size(), beat_data(39'h3030));
    end
  endtask

  task automatic test_r_backpressure();
    bit to;
    logic [DW-1:0] got;
    clear_logs();
    full_toggle = 1'b1;
    issue(39'h4000, 8'd15);
    wait_idle(300, to);
    full_toggle = 1'b0;
    total += 4;
    if (to) begin bad++; $display("FAIL rbp_timeout busy=%b want 0", bus.dram_read_busy); end
    if (rr_checks < 16) begin bad++; $display("FAIL rbp_rready_samples got=%0d want>=16", rr_checks); end
    if (rr_bad != 0) begin bad++; $display("FAIL rbp_rready_track got=%0d wrong want=0", rr_bad); end
    if (cap.size() != 16) begin bad++; $display("FAIL rbp_strobes got=%0d want=16", cap.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < cap.size()) ? cap[i] : '0;
      total++;
      if (got !== beat_data(39'h4000 + AW'(16 * i))) begin
        bad++; $display("FAIL rbp_beat%0d got=%h want=%h", i, got, beat_data(39'h4000 + AW'(16 * i)));
      end
    end
  endtask

  task automatic test_error();
    bit to;
    clear_logs();
    total += 1;
    if (bus.dram_read_error !== 1'b0) begin bad++; $display("FAIL err_pre got=%b want=0", bus.dram_read_error); end
    err_beat_cfg = 3;
    issue(39'h5000, 8'd7);
    wait_idle(200, to);
    err_beat_cfg = -1;
    total += 4;
    if (to) begin bad++; $display("FAIL err_timeout busy=%b want 0", bus.dram_read_busy); end
    if (bus.dram_read_error !== 1'b1) begin bad++; $display("FAIL err_flag got=%b want=1", bus.dram_read_error); end
    if (cap.size() != 8) begin bad++; $display("FAIL err_strobes got=%0d want=8", cap.size()); end
    if (cap.size() < 8 || cap[3] !== beat_data(39'h5030) || cap[7] !== beat_data(39'h5070)) begin
      bad++; $display("FAIL err_data got=%0d strobes want=8 with beat3 %h", cap.size(), beat_data(39'h5030));
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n = 0;
    clear_logs();
    issue(39'h6000, 8'd31);
    while (cap.size() < 4 && n < 100) begin @(negedge clk); n++; end
    total += 1;
    if (cap.size() < 4) begin bad++; $display("FAIL rstmid_progress got=%0d strobes want>=4", cap.size()); end
    rst_n = 1'b0;
    @(negedge clk);
    total += 6;
    if (bus.dram_read_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.dram_read_busy); end
    if (bus.dram_read_error !== 1'b0) begin bad++; $display("FAIL rstmid_error got=%b want=0", bus.dram_read_error); end
    if (bus.m_axi_rready !== 1'b0) begin bad++; $display("FAIL rstmid_rready got=%b want=0", bus.m_axi_rready); end
    if (bus.dram_read_data_valid !== 1'b0 || bus.dram_read_data !== '0) begin
      bad++; $display("FAIL rstmid_data got=dv %b data %h want=0/0", bus.dram_read_data_valid, bus.dram_read_data);
    end
    if (bus.m_axi_arvalid !== 1'b0) begin bad++; $display("FAIL rstmid_arvalid got=%b want=0", bus.m_axi_arvalid); end
    if (bus.m_axi_araddr !== '0 || bus.m_axi_arlen !== 8'd0) begin
      bad++; $display("FAIL rstmid_ar got=%h/%0d want=0/0", bus.m_axi_araddr, bus.m_axi_arlen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    issue(39'h2000, 8'd0);
    wait_idle(100, to);
    total += 5;
    if (to) begin bad++; $display("FAIL post_timeout busy=%b want 0", bus.dram_read_busy); end
    if (ar_addr_log.size() != 1 || ar_addr_log[0] !== 39'h2000 || ar_len_log[0] !== 8'd0) begin
      bad++; $display("FAIL post_ar got=%0d ARs want=1 at 2000 len 0", ar_addr_log.size());
    end
    if (cap.size() != 1 || cap[0] !== beat_data(39'h2000)) begin
      bad++; $display("FAIL post_data got=%0d strobes want=1 of %h", cap.size(), beat_data(39'h2000));
    end
    if (fall_dv !== 1'b1 || fall_hs != 1) begin
      bad++; $display("FAIL post_busy_fall got=dv %b hs %0d want=dv 1 hs 1", fall_dv, fall_hs);
    end
    if (bus.dram_read_error !== 1'b0) begin bad++; $display("FAIL post_error got=%b want=0", bus.dram_read_error); end
  endtask

  task automatic test_rlast_missing();
    bit to;
    clear_logs();
    rlast_drop = 1'b1;
    issue(39'h7000, 8'd3);
    wait_idle(100, to);
    rlast_drop = 1'b0;
    total += 3;
    if (to) begin bad++; $display("FAIL rlast_timeout busy=%b want 0", bus.dram_read_busy); end
    if (bus.dram_read_error !== 1'b1) begin bad++; $display("FAIL rlast_error got=%b want=1", bus.dram_read_error); end
    if (cap.size() != 4) begin bad++; $display("FAIL rlast_strobes got=%0d want=4", cap.size()); end
  endtask

  initial begin
    bus.dram_read_addr = '0;
    bus.dram_read_len  = '0;
    bus.dram_read_en   = 1'b0;
    clear_logs();
    test_reset();
    test_basic();
    test_boundary();
    test_max_burst();
    test_ar_backpressure();
    test_r_backpressure();
    test_error();
    test_reset_mid();
    test_rlast_missing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
